// File: rtl/uart_cmd_parser.sv
// uart_cmd_parser
//   Decodes 5-byte command frames (0x55, CMD, ADDR, DATA, CHK) arriving from
//   a UART receiver and turns them into register-file accesses. A good write
//   strobes wr_en and replies ACK_BYTE. A good read strobes rd_en and replies
//   with the byte read back. A frame with a bad checksum or an unknown command
//   pulses frame_err and replies NAK_BYTE. A stalled frame (inter-byte gap of
//   TIMEOUT cycles) pulses frame_err and is dropped without a reply.
//
// Ports
//   clk       : single rising-edge clock
//   rst       : synchronous, active-high reset
//   rx_data   : received byte, valid while rx_ok is high
//   rx_ok     : one-cycle "byte received" pulse
//   wr_en     : one-cycle register-write strobe
//   wr_addr   : register write address (holds between strobes)
//   wr_data   : register write data (holds between strobes)
//   rd_en     : one-cycle register-read strobe
//   rd_addr   : register read address (holds between strobes)
//   rd_data   : read data, valid the cycle after rd_en
//   tx_start  : one-cycle pulse to start a transmission of tx_data
//   tx_data   : reply byte (holds between strobes)
//   tx_busy   : transmitter busy flag
//   frame_err : one-cycle pulse on checksum error, bad command or timeout
module uart_cmd_parser #(
    parameter int         TIMEOUT  = 50000,
    parameter logic [7:0] ACK_BYTE = 8'hAA,
    parameter logic [7:0] NAK_BYTE = 8'hEE
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] rx_data,
    input  logic       rx_ok,
    output logic       wr_en,
    output logic [7:0] wr_addr,
    output logic [7:0] wr_data,
    output logic       rd_en,
    output logic [7:0] rd_addr,
    input  logic [7:0] rd_data,
    output logic       tx_start,
    output logic [7:0] tx_data,
    input  logic       tx_busy,
    output logic       frame_err
);

    localparam logic [7:0] HEADER  = 8'h55;
    localparam logic [7:0] CMD_WR  = 8'h01;
    localparam logic [7:0] CMD_RD  = 8'h02;
    localparam int         CNT_W   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE,
        CMD,
        ADDR,
        DATA,
        CHK,
        EXEC,
        RDWAIT,
        RESP
    } state_t;

    state_t           state;
    state_t           next_state;

    logic [7:0]       cmd_field;
    logic [7:0]       addr_field;
    logic [7:0]       data_field;
    logic             chk_ok;
    logic [7:0]       reply;
    logic [CNT_W-1:0] gap_cnt;

    // Last values presented on the strobed outputs, so the buses hold
    // steady between strobes even while a new frame is being collected.
    logic [7:0]       wr_addr_hold;
    logic [7:0]       wr_data_hold;
    logic [7:0]       rd_addr_hold;
    logic [7:0]       tx_data_hold;

    logic             in_frame;
    logic             timeout_hit;
    logic             good_wr;
    logic             good_rd;

    assign in_frame    = (state == CMD) || (state == ADDR) ||
                         (state == DATA) || (state == CHK);
    // A byte arriving in the same cycle as the timeout wins.
    assign timeout_hit = in_frame && !rx_ok && (gap_cnt == CNT_MAX);
    assign good_wr     = chk_ok && (cmd_field == CMD_WR);
    assign good_rd     = chk_ok && (cmd_field == CMD_RD);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        wr_en      = 1'b0;
        rd_en      = 1'b0;
        tx_start   = 1'b0;
        frame_err  = 1'b0;
        case (state)
            IDLE: begin
                if (rx_ok && (rx_data == HEADER)) begin
                    next_state = CMD;
                end
            end
            CMD, ADDR, DATA, CHK: begin
                if (rx_ok) begin
                    case (state)
                        CMD:     next_state = ADDR;
                        ADDR:    next_state = DATA;
                        DATA:    next_state = CHK;
                        default: next_state = EXEC;
                    endcase
                end else if (timeout_hit) begin
                    frame_err  = 1'b1;
                    next_state = IDLE;
                end
            end
            EXEC: begin
                if (good_wr) begin
                    wr_en      = 1'b1;
                    next_state = RESP;
                end else if (good_rd) begin
                    rd_en      = 1'b1;
                    next_state = RDWAIT;
                end else begin
                    frame_err  = 1'b1;
                    next_state = RESP;
                end
            end
            RDWAIT: begin
                next_state = RESP;
            end
            RESP: begin
                if (!tx_busy) begin
                    tx_start   = 1'b1;
                    next_state = IDLE;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
        // A reset cycle must never leak a strobe for the aborted frame.
        if (rst) begin
            wr_en     = 1'b0;
            rd_en     = 1'b0;
            tx_start  = 1'b0;
            frame_err = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cmd_field    <= 8'h00;
            addr_field   <= 8'h00;
            data_field   <= 8'h00;
            chk_ok       <= 1'b0;
            reply        <= 8'h00;
            gap_cnt      <= '0;
            wr_addr_hold <= 8'h00;
            wr_data_hold <= 8'h00;
            rd_addr_hold <= 8'h00;
            tx_data_hold <= 8'h00;
        end else begin
            if (rx_ok) begin
                case (state)
                    CMD:     cmd_field  <= rx_data;
                    ADDR:    addr_field <= rx_data;
                    DATA:    data_field <= rx_data;
                    CHK:     chk_ok     <= (rx_data == (cmd_field ^ addr_field ^ data_field));
                    default: ;
                endcase
            end

            if (rx_ok) begin
                gap_cnt <= '0;
            end else if (in_frame && (gap_cnt != CNT_MAX)) begin
                gap_cnt <= gap_cnt + 1'b1;
            end

            if (state == EXEC) begin
                if (good_wr) begin
                    reply <= ACK_BYTE;
                end else if (!good_rd) begin
                    reply <= NAK_BYTE;
                end
            end else if (state == RDWAIT) begin
                reply <= rd_data;
            end

            if (wr_en) begin
                wr_addr_hold <= addr_field;
                wr_data_hold <= data_field;
            end
            if (rd_en) begin
                rd_addr_hold <= addr_field;
            end
            if (tx_start) begin
                tx_data_hold <= reply;
            end
        end
    end

    assign wr_addr = wr_en    ? addr_field : wr_addr_hold;
    assign wr_data = wr_en    ? data_field : wr_data_hold;
    assign rd_addr = rd_en    ? addr_field : rd_addr_hold;
    assign tx_data = tx_start ? reply      : tx_data_hold;

endmodule

// File: tb/tb_uart_cmd_parser.sv
// tb_uart_cmd_parser
//   Directed-frame bench for uart_cmd_parser (TIMEOUT=8). Stimulus pushes the
//   expected strobe events (kind, bus values, cycle) into a queue; a monitor
//   on the falling edge pops one entry per observed strobe and compares.
module tb_uart_cmd_parser;

    localparam int K_WR  = 0;
    localparam int K_RD  = 1;
    localparam int K_ERR = 2;
    localparam int K_TX  = 3;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] rx_data;
    logic       rx_ok;
    logic       wr_en;
    logic [7:0] wr_addr;
    logic [7:0] wr_data;
    logic       rd_en;
    logic [7:0] rd_addr;
    logic [7:0] rd_data = 8'h00;
    logic       tx_start;
    logic [7:0] tx_data;
    logic       tx_busy;
    logic       frame_err;

    typedef struct {
        int         kind;
        logic [7:0] a;
        logic [7:0] b;
        int         cyc;
    } ev_t;

    ev_t        sb[$];
    int         cyc = 0;
    int         n_total = 0;
    int         n_pass = 0;
    logic [7:0] rd_reply = 8'h00;

    uart_cmd_parser #(
        .TIMEOUT (8),
        .ACK_BYTE(8'hAA),
        .NAK_BYTE(8'hEE)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .rx_data  (rx_data),
        .rx_ok    (rx_ok),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .rd_en    (rd_en),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
        .tx_start (tx_start),
        .tx_data  (tx_data),
        .tx_busy  (tx_busy),
        .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Register file model: read data appears the cycle after rd_en.
    always @(posedge clk) rd_data <= rd_en ? rd_reply : 8'h00;

    task automatic check(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic match(input int kind, input logic [7:0] a, input logic [7:0] b);
        ev_t e;
        if (sb.size() == 0) begin
            n_total++;
            $display("FAIL unexpected_event: got kind %0d (0x%0h,0x%0h) at cycle %0d, expected none",
                     kind, a, b, cyc);
        end else begin
            e = sb.pop_front();
            check("ev_kind", kind, e.kind);
            check("ev_a", int'(a), int'(e.a));
            check("ev_b", int'(b), int'(e.b));
            check("ev_cycle", cyc, e.cyc);
        end
    endtask

    always @(negedge clk) begin
        if (rst === 1'b0) begin
            if (wr_en && rd_en) begin
                n_total++;
                $display("FAIL wr_rd_exclusive: got both high at cycle %0d, expected at most one", cyc);
            end
            if (wr_en === 1'b1)     match(K_WR, wr_addr, wr_data);
            if (rd_en === 1'b1)     match(K_RD, rd_addr, 8'h00);
            if (frame_err === 1'b1) match(K_ERR, 8'h00, 8'h00);
            if (tx_start === 1'b1)  match(K_TX, tx_data, 8'h00);
        end
    end

    function automatic ev_t mk(input int kind, input logic [7:0] a, input logic [7:0] b, input int c);
        ev_t e;
        e.kind = kind;
        e.a    = a;
        e.b    = b;
        e.cyc  = c;
        return e;
    endfunction

    // All driving tasks start and end 1 time unit after a rising edge.
    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, output int c);
        rx_data = b;
        rx_ok   = 1'b1;
        c       = cyc;
        @(posedge clk);
        #1;
        rx_ok   = 1'b0;
        rx_data = 8'h00;
    endtask

    task automatic send_frame(input logic [7:0] b1, input logic [7:0] b2,
                              input logic [7:0] b3, input logic [7:0] b4, output int c);
        int t;
        send_byte(8'h55, t);
        send_byte(b1, t);
        send_byte(b2, t);
        send_byte(b3, t);
        send_byte(b4, c);
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_wr_en"}, int'(wr_en), 0);
        check({tag, "_rd_en"}, int'(rd_en), 0);
        check({tag, "_tx_start"}, int'(tx_start), 0);
        check({tag, "_frame_err"}, int'(frame_err), 0);
        check({tag, "_wr_addr"}, int'(wr_addr), 0);
        check({tag, "_wr_data"}, int'(wr_data), 0);
        check({tag, "_rd_addr"}, int'(rd_addr), 0);
        check({tag, "_tx_data"}, int'(tx_data), 0);
    endtask

    initial begin
        int c;
        int t;
        rst     = 1'b1;
        rx_data = 8'h00;
        rx_ok   = 1'b0;
        tx_busy = 1'b0;
        idle(3);
        rst = 1'b0;
        check_outputs_zero("reset");

        // Good write, first byte in the very cycle reset is released.
        send_frame(8'h01, 8'h10, 8'hA5, 8'hB4, c);
        sb.push_back(mk(K_WR, 8'h10, 8'hA5, c + 1));
        sb.push_back(mk(K_TX, 8'hAA, 8'h00, c + 2));
        idle(6);
        check("hold_wr_addr", int'(wr_addr), 'h10);
        check("hold_wr_data", int'(wr_data), 'hA5);
        check("hold_tx_data", int'(tx_data), 'hAA);

        // Good read.
        rd_reply = 8'h3C;
        send_frame(8'h02, 8'h20, 8'h00, 8'h22, c);
        sb.push_back(mk(K_RD, 8'h20, 8'h00, c + 1));
        sb.push_back(mk(K_TX, 8'h3C, 8'h00, c + 3));
        idle(6);
        check("hold_rd_addr", int'(rd_addr), 'h20);
        check("hold_tx_data_rd", int'(tx_data), 'h3C);

        // Junk byte in IDLE is silently discarded, then a bad checksum.
        send_byte(8'h12, t);
        idle(2);
        send_frame(8'h01, 8'h10, 8'hA5, 8'h00, c);
        sb.push_back(mk(K_ERR, 8'h00, 8'h00, c + 1));
        sb.push_back(mk(K_TX, 8'hEE, 8'h00, c + 2));
        idle(6);

        // Unknown command with a correct checksum.
        send_frame(8'h03, 8'h10, 8'hA5, 8'hB6, c);
        sb.push_back(mk(K_ERR, 8'h00, 8'h00, c + 1));
        sb.push_back(mk(K_TX, 8'hEE, 8'h00, c + 2));
        idle(6);

        // Inter-byte timeout: error 8 cycles after the 01 byte, no reply.
        send_byte(8'h55, t);
        send_byte(8'h01, c);
        sb.push_back(mk(K_ERR, 8'h00, 8'h00, c + 8));
        idle(12);
        send_frame(8'h01, 8'h11, 8'h5A, 8'h4A, c);
        sb.push_back(mk(K_WR, 8'h11, 8'h5A, c + 1));
        sb.push_back(mk(K_TX, 8'hAA, 8'h00, c + 2));
        idle(6);

        // A byte landing exactly on the last timeout cycle is accepted.
        send_byte(8'h55, t);
        send_byte(8'h01, c);
        idle(7);
        send_byte(8'h30, t);
        send_byte(8'h0F, t);
        send_byte(8'h3E, c);
        sb.push_back(mk(K_WR, 8'h30, 8'h0F, c + 1));
        sb.push_back(mk(K_TX, 8'hAA, 8'h00, c + 2));
        idle(6);

        // Busy transmitter: reply waits for tx_busy to drop; a byte arriving
        // in RESP is dropped so the following headerless bytes are ignored.
        tx_busy = 1'b1;
        send_frame(8'h01, 8'h10, 8'hA5, 8'hB4, c);
        sb.push_back(mk(K_WR, 8'h10, 8'hA5, c + 1));
        idle(1);
        send_byte(8'h55, t);
        idle(17);
        sb.push_back(mk(K_TX, 8'hAA, 8'h00, c + 20));
        tx_busy = 1'b0;
        idle(2);
        send_byte(8'h01, t);
        send_byte(8'h10, t);
        send_byte(8'hA5, t);
        send_byte(8'hB4, t);
        idle(6);

        // Reset mid-frame: no strobes, then a normal write.
        send_byte(8'h55, t);
        send_byte(8'h01, t);
        send_byte(8'h10, t);
        rst = 1'b1;
        idle(2);
        rst = 1'b0;
        check_outputs_zero("rst_mid");
        send_frame(8'h01, 8'h10, 8'hA5, 8'hB4, c);
        sb.push_back(mk(K_WR, 8'h10, 8'hA5, c + 1));
        sb.push_back(mk(K_TX, 8'hAA, 8'h00, c + 2));
        idle(6);

        // Reset while waiting in RESP: the pending reply is never sent.
        tx_busy = 1'b1;
        send_frame(8'h01, 8'h44, 8'h07, 8'h42, c);
        sb.push_back(mk(K_WR, 8'h44, 8'h07, c + 1));
        idle(2);
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        tx_busy = 1'b0;
        idle(6);
        check("rst_resp_tx_data", int'(tx_data), 0);
        check("rst_resp_wr_addr", int'(wr_addr), 0);

        idle(10);
        check("scoreboard_drained", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/uart_cmd_parser.md
UART_CMD_PARSER -- requirements
Module: uart_cmd_parser

Interface
REQ-001 Parameter TIMEOUT, default 50000, is the maximum number of clk cycles allowed between consecutive bytes of one frame.
REQ-002 Parameter ACK_BYTE, default 8'hAA, is the reply byte for a good write frame.
REQ-003 Parameter NAK_BYTE, default 8'hEE, is the reply byte for a bad frame.
REQ-004 clk  input  1  is the single clock; all logic is rising-edge.
REQ-005 rst  input  1  is the reset: synchronous, active-high.
REQ-006 rx_data  input  8  is the received byte from the UART receiver.
REQ-007 rx_ok  input  1  is a one-cycle pulse meaning rx_data is valid this cycle.
REQ-008 wr_en  output  1  is a one-cycle register-write strobe.
REQ-009 wr_addr  output  8  is the register write address.
REQ-010 wr_data  output  8  is the register write data.
REQ-011 rd_en  output  1  is a one-cycle register-read strobe.
REQ-012 rd_addr  output  8  is the register read address.
REQ-013 rd_data  input  8  is the read data, valid exactly 1 cycle after rd_en.
REQ-014 tx_start  output  1  is a one-cycle pulse telling the UART transmitter to send tx_data.
REQ-015 tx_data  output  8  is the reply byte, stable from tx_start until tx_busy falls.
REQ-016 tx_busy  input  1  is high while the transmitter is sending.
REQ-017 frame_err  output  1  is a one-cycle pulse on a checksum error, bad command, or inter-byte timeout.

Function
REQ-018 Frame format: 0x55 header, CMD, ADDR, DATA, CHK; CHK = CMD ^ ADDR ^ DATA.
REQ-019 Valid CMD values: 0x01 is write; 0x02 is read (DATA is don't-care but is still included in CHK).
REQ-020 FSM states: IDLE, CMD, ADDR, DATA, CHK, EXEC, RDWAIT, RESP.
REQ-021 IDLE transitions:
- rx_ok with rx_data==0x55 -> CMD.
- any other byte is discarded; no error is flagged.
REQ-022 In each of CMD/ADDR/DATA, rx_ok latches the byte into its field register and advances one state.
REQ-023 In CHK, rx_ok compares rx_data with the computed XOR and always goes to EXEC.
REQ-024 EXEC lasts 1 cycle and branches on the result:
- Good write: wr_en=1, wr_addr/wr_data = latched fields; reply is ACK_BYTE; -> RESP.
- Good read: rd_en=1, rd_addr = latched ADDR; -> RDWAIT.
- Checksum mismatch or CMD not 0x01/0x02: frame_err=1; reply is NAK_BYTE; no wr_en/rd_en; -> RESP.
REQ-025 RDWAIT lasts 1 cycle: it captures rd_data as the reply byte, then -> RESP.
REQ-026 RESP:
- Waits while tx_busy=1.
- In the first cycle with tx_busy=0, pulses tx_start for 1 cycle with tx_data = reply byte, then -> IDLE.
REQ-027 Latency: EXEC is the cycle after the CHK byte's rx_ok; with tx_busy=0, tx_start follows:
- write or error: 2 cycles after the CHK rx_ok.
- read: 3 cycles after the CHK rx_ok.
REQ-028 Inter-byte timeout:
- A counter clears on every rx_ok and increments each cycle while in CMD, ADDR, DATA or CHK.
- When it reaches TIMEOUT-1 with no rx_ok that cycle: frame_err pulses, FSM -> IDLE, no reply is sent.
- A simultaneous rx_ok wins over the timeout.
REQ-029 The counter does not count in IDLE, EXEC, RDWAIT or RESP, and saturates at TIMEOUT-1.
REQ-030 A 0x55 byte received in CMD/ADDR/DATA/CHK is treated as data, not as a resync.
REQ-031 rx_ok pulses that arrive in EXEC, RDWAIT or RESP are dropped; the FSM then resumes in IDLE.
REQ-032 wr_en, rd_en, tx_start and frame_err are never high for more than 1 consecutive cycle.
REQ-033 At most one of wr_en and rd_en is high in any cycle.
REQ-034 wr_addr, wr_data, rd_addr and tx_data hold their last value between strobes.

Reset
REQ-035 While rst=1 at a clk edge:
- FSM -> IDLE; field registers, reply register and timeout counter -> 0.
- All outputs -> 0.
REQ-036 rst asserted mid-frame or in RESP aborts the frame: no strobe and no tx_start occur for it.
REQ-037 The first byte accepted after reset is the first rx_ok in the cycle after rst deasserts.

Verification
REQ-038 The bench shall cover these directed scenarios:
- Write: bytes 55 01 10 A5 B4 -> wr_en 1 cycle, wr_addr=10, wr_data=A5; tx_start with tx_data=AA 2 cycles after the CHK byte.
- Read: bytes 55 02 20 00 22, rd_data=3C the cycle after rd_en -> rd_addr=20; tx_start with tx_data=3C 3 cycles after the CHK byte.
- Bad checksum: bytes 55 01 10 A5 00 -> frame_err pulse, no wr_en, tx_data=EE.
- Timeout: with TIMEOUT=8, send 55 01 then no byte -> frame_err on the 8th cycle after the 01 byte, FSM back in IDLE; next frame 55 01 10 A5 B4 is accepted normally.
- Busy transmitter: tx_busy=1 held for 20 cycles after a good write frame -> tx_start is delayed until the first cycle with tx_busy=0; a byte received in RESP is dropped.
- Reset mid-frame: rst after 55 01 10 -> no strobes; a following complete frame works as the write scenario.
